// File: rtl/seq_decoder_pkg.sv
// seq_decoder_pkg: shared constants for the sequence decoder.
//   state_e     - FSM state encoding (IDLE / DIRECT / SCAN)
//   MODE_DIRECT - mode input value selecting direct decode
//   MODE_SCAN   - mode input value selecting the scanning sweep
package seq_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_e;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/seq_decoder_dwell_counter.sv
// dwell_counter: free-running modulo-DWELL counter for the scan sweep.
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset (count -> 0)
//   clr  - synchronous clear; count is held at 0 while asserted
//   tick - high during the last cycle of each DWELL-cycle window
module dwell_counter #(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    // A 1-bit counter is kept even for DWELL=1; it simply stays at 0
    // so tick is permanently high and the scan advances every cycle.
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CW'(DWELL - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || tick) cnt_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/seq_decoder.sv
// seq_decoder: binary select -> registered one-hot decoder with an optional
// scanning mode that walks the one-hot bit across all outputs.
//   clk       - clock, rising edge
//   rst       - asynchronous active-high reset
//   en        - block enable; when low the outputs clear on the next edge
//   mode      - 0 direct decode, 1 scan (ignored when scan is compiled out)
//   in_valid  - select word valid
//   in        - select word
//   in_ready  - select word accepted on in_valid && in_ready
//   out       - registered one-hot output
//   out_valid - out holds a valid one-hot code
//   idx       - binary index of the asserted out bit
// Build option: define SEQ_DECODER_SCAN_EN to include the scan state and
// dwell counter; without it mode is ignored and in_ready follows en.
module seq_decoder
    import seq_decoder_pkg::*;
#(
    parameter  int SEL_W = 3,
    parameter  int DWELL = 4,
    localparam int OUT_W = 2**SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             in_valid,
    input  logic [SEL_W-1:0] in,
    output logic             in_ready,
    output logic [OUT_W-1:0] out,
    output logic             out_valid,
    output logic [SEL_W-1:0] idx
);

    state_e           state_q, state_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic             vld_q, vld_d;
    logic             scan_req;
    logic             tick;
    logic             accept;

`ifdef SEQ_DECODER_SCAN_EN
    logic dwell_clr;

    assign scan_req = en && (mode == MODE_SCAN);
    // Not ready during the cycle mode drops out of SCAN: that edge only
    // tears the scan down, a word arrives from IDLE one cycle later.
    assign in_ready = en && (mode == MODE_DIRECT) && (state_q != SCAN);
    // Held clear on the entry edge too, so the first scan position gets a
    // full DWELL cycles.
    assign dwell_clr = (state_q != SCAN) || (state_d != SCAN);

    dwell_counter #(.DWELL(DWELL)) u_dwell (
        .clk  (clk),
        .rst  (rst),
        .clr  (dwell_clr),
        .tick (tick)
    );
`else
    logic unused_mode;

    assign unused_mode = mode;
    assign scan_req    = 1'b0;
    assign tick        = 1'b0;
    assign in_ready    = en;
`endif

    assign accept = in_valid && in_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; en=0 dominates everything else.
    always_comb begin
        state_d = state_q;
        if (!en)                  state_d = IDLE;
        else if (scan_req)        state_d = SCAN;
        else if (state_q == SCAN) state_d = IDLE;
        else if (accept)          state_d = DIRECT;
    end

    // Output next-values, keyed on the state being entered.
    always_comb begin
        out_d = out_q;
        idx_d = idx_q;
        vld_d = vld_q;
        case (state_d)
            DIRECT: begin
                if (accept) begin
                    idx_d = in;
                    out_d = OUT_W'(1) << in;
                    vld_d = 1'b1;
                end
            end
            SCAN: begin
                if (state_q != SCAN) begin
                    idx_d = '0;
                    out_d = OUT_W'(1);
                    vld_d = 1'b1;
                end else if (tick) begin
                    // idx wraps naturally at OUT_W-1 -> 0
                    idx_d = idx_q + SEL_W'(1);
                    out_d = OUT_W'(1) << idx_d;
                end
            end
            default: begin
                idx_d = '0;
                out_d = '0;
                vld_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
            idx_q <= '0;
            vld_q <= 1'b0;
        end else begin
            out_q <= out_d;
            idx_q <= idx_d;
            vld_q <= vld_d;
        end
    end

    assign out       = out_q;
    assign idx       = idx_q;
    assign out_valid = vld_q;

endmodule

// File: tb/tb_seq_decoder.sv
// Self-checking bench for seq_decoder. Two instances share the inputs:
// u0 with DWELL=4 and u1 with DWELL=1. The reference model works from the
// behavioural rules: a scan position is (cycles since scan entry / DWELL)
// mod OUT_W; a direct accept loads 1<<sel.
module tb_seq_decoder;

    localparam int SEL_W = 3;
    localparam int OUT_W = 8;
`ifdef SEQ_DECODER_SCAN_EN
    localparam bit SCAN_ON = 1'b1;
`else
    localparam bit SCAN_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             mode = 1'b0;
    logic             in_valid = 1'b0;
    logic [SEL_W-1:0] sel = '0;

    logic             o_rdy [2];
    logic [OUT_W-1:0] o_out [2];
    logic             o_vld [2];
    logic [SEL_W-1:0] o_idx [2];

    logic [OUT_W-1:0] e_out [2];
    logic             e_vld [2];
    logic [SEL_W-1:0] e_idx [2];
    bit               scanning;
    int               t;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_decoder #(.SEL_W(SEL_W), .DWELL(4)) u0 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid), .in(sel),
        .in_ready(o_rdy[0]), .out(o_out[0]), .out_valid(o_vld[0]), .idx(o_idx[0])
    );

    seq_decoder #(.SEL_W(SEL_W), .DWELL(1)) u1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid), .in(sel),
        .in_ready(o_rdy[1]), .out(o_out[1]), .out_valid(o_vld[1]), .idx(o_idx[1])
    );

    function automatic int dw(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    function automatic logic exp_ready();
        return en && !(SCAN_ON && mode) && !scanning;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            e_out[k] = '0;
            e_idx[k] = '0;
            e_vld[k] = 1'b0;
        end
        scanning = 1'b0;
    endtask

    // Advance the model by one rising edge using the current inputs.
    task automatic model_edge();
        if (rst || !en) begin
            model_clear();
        end else if (SCAN_ON && mode) begin
            if (!scanning) begin
                scanning = 1'b1;
                t = 0;
            end else begin
                t++;
            end
            for (int k = 0; k < 2; k++) begin
                e_idx[k] = SEL_W'((t / dw(k)) % OUT_W);
                e_out[k] = OUT_W'(1) << e_idx[k];
                e_vld[k] = 1'b1;
            end
        end else if (scanning) begin
            model_clear();
        end else if (in_valid) begin
            for (int k = 0; k < 2; k++) begin
                e_idx[k] = sel;
                e_out[k] = OUT_W'(1) << sel;
                e_vld[k] = 1'b1;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        model_clear();
        #2;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (o_out[k] !== 8'h00 || o_idx[k] !== 3'd0 || o_vld[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset u%0d: out=%h idx=%0d vld=%b, want 00/0/0", k, o_out[k], o_idx[k], o_vld[k]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_direct();
        en = 1'b1; mode = 1'b0; in_valid = 1'b1; sel = 3'b101;
        #1;
        checks++;
        if (o_rdy[0] !== 1'b1) begin
            errors++;
            $display("FAIL direct_ready: in_ready=%b, want 1", o_rdy[0]);
        end
        cycle();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (o_out[k] !== 8'h20 || o_idx[k] !== 3'd5 || o_vld[k] !== 1'b1) begin
                errors++;
                $display("FAIL direct u%0d: out=%h idx=%0d vld=%b, want 20/5/1", k, o_out[k], o_idx[k], o_vld[k]);
            end
        end
    endtask

    task automatic test_sweep();
        en = 1'b1; mode = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < OUT_W; i++) begin
            sel = SEL_W'(i);
            cycle();
            checks++;
            if (o_out[0] !== e_out[0] || o_idx[0] !== e_idx[0] || $countones(o_out[0]) != 1) begin
                errors++;
                $display("FAIL sweep i=%0d: out=%h idx=%0d, want %h/%0d", i, o_out[0], o_idx[0], e_out[0], e_idx[0]);
            end
        end
    endtask

    task automatic test_hold();
        in_valid = 1'b0;
        sel = 3'd1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (o_out[0] !== 8'h80 || o_idx[0] !== 3'd7 || o_vld[0] !== 1'b1) begin
                errors++;
                $display("FAIL hold: out=%h idx=%0d vld=%b, want 80/7/1", o_out[0], o_idx[0], o_vld[0]);
            end
        end
    endtask

    task automatic test_random(input int n, input bit use_mode);
        for (int i = 0; i < n; i++) begin
            en       = ($urandom_range(0, 7) != 0);
            mode     = use_mode ? ($urandom_range(0, 3) == 0 ? ~mode : mode) : 1'b0;
            in_valid = $urandom_range(0, 1);
            sel      = SEL_W'($urandom);
            #1;
            checks++;
            if (o_rdy[0] !== exp_ready()) begin
                errors++;
                $display("FAIL rand_ready i=%0d: in_ready=%b, want %b", i, o_rdy[0], exp_ready());
            end
            cycle();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (o_out[k] !== e_out[k] || o_idx[k] !== e_idx[k] || o_vld[k] !== e_vld[k]) begin
                    errors++;
                    $display("FAIL rand u%0d i=%0d: out=%h idx=%0d vld=%b, want %h/%0d/%b",
                             k, i, o_out[k], o_idx[k], o_vld[k], e_out[k], e_idx[k], e_vld[k]);
                end
            end
        end
    endtask

`ifdef SEQ_DECODER_SCAN_EN
    task automatic test_scan();
        logic [OUT_W-1:0] prev;
        en = 1'b1; mode = 1'b0; in_valid = 1'b0;
        cycle();
        mode = 1'b1;
        prev = '0;
        for (int i = 0; i < OUT_W * 4 + 4; i++) begin
            cycle();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (o_out[k] !== e_out[k] || o_idx[k] !== e_idx[k] || o_vld[k] !== 1'b1 ||
                    $countones(o_out[k]) != 1) begin
                    errors++;
                    $display("FAIL scan u%0d c=%0d: out=%h idx=%0d vld=%b, want %h/%0d/1",
                             k, i, o_out[k], o_idx[k], o_vld[k], e_out[k], e_idx[k]);
                end
            end
            if (prev == 8'h80 && o_out[0] != 8'h80) begin
                checks++;
                if (o_out[0] !== 8'h01) begin
                    errors++;
                    $display("FAIL scan_wrap: out=%h, want 01", o_out[0]);
                end
            end
            prev = o_out[0];
        end
    endtask

    task automatic test_scan_abort();
        en = 1'b1; mode = 1'b1; in_valid = 1'b0;
        for (int n = 0; n < 64 && !(scanning && e_idx[0] == 3'd3); n++) cycle();
        checks++;
        if (o_idx[0] !== 3'd3) begin
            errors++;
            $display("FAIL abort_setup: idx=%0d, want 3", o_idx[0]);
        end
        en = 1'b0; in_valid = 1'b1; sel = 3'd6;
        cycle();
        checks++;
        if (o_out[0] !== 8'h00 || o_vld[0] !== 1'b0 || o_idx[0] !== 3'd0) begin
            errors++;
            $display("FAIL abort: out=%h idx=%0d vld=%b, want 00/0/0", o_out[0], o_idx[0], o_vld[0]);
        end
    endtask

    task automatic test_mode_fall();
        en = 1'b1; mode = 1'b1; in_valid = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        mode = 1'b0; in_valid = 1'b1; sel = 3'd7;
        #1;
        checks++;
        if (o_rdy[0] !== 1'b0) begin
            errors++;
            $display("FAIL modefall_ready: in_ready=%b, want 0", o_rdy[0]);
        end
        cycle();
        checks++;
        if (o_out[0] !== 8'h00 || o_vld[0] !== 1'b0) begin
            errors++;
            $display("FAIL modefall: out=%h vld=%b, want 00/0", o_out[0], o_vld[0]);
        end
        cycle();
        checks++;
        if (o_out[0] !== 8'h80 || o_idx[0] !== 3'd7) begin
            errors++;
            $display("FAIL modefall_accept: out=%h idx=%0d, want 80/7", o_out[0], o_idx[0]);
        end
    endtask

    task automatic test_async_reset();
        en = 1'b1; mode = 1'b1; in_valid = 1'b0;
        for (int n = 0; n < 64 && !(scanning && e_idx[0] == 3'd6); n++) cycle();
        checks++;
        if (o_idx[0] !== 3'd6) begin
            errors++;
            $display("FAIL areset_setup: idx=%0d, want 6", o_idx[0]);
        end
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        checks++;
        if (o_out[0] !== 8'h00 || o_vld[0] !== 1'b0 || o_idx[0] !== 3'd0) begin
            errors++;
            $display("FAIL areset: out=%h idx=%0d vld=%b, want 00/0/0", o_out[0], o_idx[0], o_vld[0]);
        end
        @(negedge clk);
        rst = 1'b0; mode = 1'b0; in_valid = 1'b1; sel = 3'b010;
        cycle();
        checks++;
        if (o_out[0] !== 8'h04 || o_idx[0] !== 3'd2 || o_vld[0] !== 1'b1) begin
            errors++;
            $display("FAIL areset_after: out=%h idx=%0d vld=%b, want 04/2/1", o_out[0], o_idx[0], o_vld[0]);
        end
    endtask
`else
    task automatic test_noscan_mode();
        en = 1'b1; mode = 1'b1; in_valid = 1'b1; sel = 3'b111;
        #1;
        checks++;
        if (o_rdy[0] !== 1'b1) begin
            errors++;
            $display("FAIL noscan_ready: in_ready=%b, want 1", o_rdy[0]);
        end
        cycle();
        checks++;
        if (o_out[0] !== 8'h80 || o_idx[0] !== 3'd7 || o_vld[0] !== 1'b1) begin
            errors++;
            $display("FAIL noscan: out=%h idx=%0d vld=%b, want 80/7/1", o_out[0], o_idx[0], o_vld[0]);
        end
    endtask

    task automatic test_async_reset();
        en = 1'b1; mode = 1'b0; in_valid = 1'b1; sel = 3'd6;
        cycle();
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        checks++;
        if (o_out[0] !== 8'h00 || o_vld[0] !== 1'b0 || o_idx[0] !== 3'd0) begin
            errors++;
            $display("FAIL areset: out=%h idx=%0d vld=%b, want 00/0/0", o_out[0], o_idx[0], o_vld[0]);
        end
        @(negedge clk);
        rst = 1'b0; sel = 3'b010;
        cycle();
        checks++;
        if (o_out[0] !== 8'h04) begin
            errors++;
            $display("FAIL areset_after: out=%h, want 04", o_out[0]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_direct();
        test_sweep();
        test_hold();
        test_random(60, 1'b0);
`ifdef SEQ_DECODER_SCAN_EN
        test_scan();
        test_scan_abort();
        test_mode_fall();
        test_async_reset();
        test_random(300, 1'b1);
`else
        test_noscan_mode();
        test_async_reset();
        test_random(200, 1'b1);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
